quad_step_decoder: RTL and testbench
====================================

# quad_step_decoder

Quadrature encoder front end that sits directly upstream of the 4-bit up/down counter. It synchronizes and glitch-filters the two asynchronous encoder channels, then decodes the Gray-code sequence. It emits a single-cycle step pulse and a direction level that drive the counter's `on` and `up_down` inputs directly. Illegal double-bit transitions are flagged and never produce a step.

## Interface
- `FILTER_LEN`, default 3: consecutive synchronized samples a channel must hold a new value before it is accepted; legal range 1..15.
- `clk`  input  1  rising-edge clock, shared with the counter.
- `reset`  input  1  asynchronous, active-high reset.
- `enc_a`  input  1  encoder channel A; asynchronous to `clk`.
- `enc_b`  input  1  encoder channel B; asynchronous to `clk`.
- `clr_err`  input  1  synchronous clear of `err_flag`.
- `on`  output  1  one-cycle step pulse; connects to counter `on`.
- `up_down`  output  1  direction of the last legal step, 1 = up; connects to counter `up_down`.
- `err`  output  1  one-cycle pulse on an illegal transition.
- `err_flag`  output  1  sticky error indicator.

## Operation
- **Synchronizer:** two flops per channel: `enc_x` → `s1_x` → `s2_x`.
- **Filter (per channel, independent):**
  - Counter `cnt_x`, 4 bits.
  - If `s2_x == filt_x`: `cnt_x <= 0`.
  - Else, if `cnt_x == FILTER_LEN-1`: `filt_x <= s2_x` and `cnt_x <= 0`.
  - Otherwise `cnt_x` increments.
  - A glitch shorter than `FILTER_LEN` samples is discarded.
- **Decoder:**
  - `prev <= {filt_a, filt_b}` every cycle.
  - Compare `cur = {filt_a, filt_b}` against `prev`:
    - Up sequence: 00→01→11→10→00. Sets `on <= 1` and `up_down <= 1`.
    - Down sequence: 00→10→11→01→00. Sets `on <= 1` and `up_down <= 0`.
    - `cur == prev`: `on <= 0`; `up_down` holds.
    - Both bits differ (00↔11, 01↔10): `err <= 1`, `on <= 0`, `up_down` holds.
- **Error flag:**
  - `err_flag` sets on any `err`.
  - `clr_err` clears it.
  - Same-cycle set and clear: set wins.
- **Arming:**
  - After reset deassertion, a 2-bit init counter runs for 3 cycles.
  - During that window, `filt_x <= s2_x` every cycle, unfiltered; `prev` tracks as normal; `on` and `err` are forced to 0.
  - The block is armed from the 4th cycle onward.
  - Effect: whatever static encoder position is present at reset never produces a step or an error.
- **Reset values:** `s1`, `s2`, `filt`, `prev` = 0; `cnt` = 0; `on` = 0; `up_down` = 1; `err` = 0; `err_flag` = 0; init counter = 0 (disarmed).
- **Reset mid-operation:** all state clears immediately (asynchronous), any in-flight step is lost, and the arming window restarts.

## Timing
- Let edge k be the first edge that captures a new `enc_a` value into `s1_a`, with the value held stable thereafter.
  - `s2_a` updates at edge k+1.
  - `filt_a` updates at edge k+1+`FILTER_LEN`.
  - `on` is high for exactly one cycle, after edge k+2+`FILTER_LEN` (default: after edge k+5).
- `up_down` is registered in the same edge as `on`, so the counter sees both `on` and `up_down` valid together at its next edge.
- `err` follows the same latency as `on`.
- Independent filters can accept A and B changes in the same cycle; that case is an illegal transition by definition.
- Maximum step rate: one legal step per `FILTER_LEN`+1 cycles per channel change. Faster encoder motion is filtered away or reported as `err`; it is never miscounted silently.
- `on` is never high for two consecutive cycles from a single channel change.
- `on` and `err` are never high in the same cycle.

## Test plan
- **Reset at nonzero position:** hold `enc_a`=1, `enc_b`=1 through reset and 20 cycles after release → `on`=0 and `err`=0 throughout, `up_down`=1, downstream counter stays 0.
- **Forward rotation:** from 00, drive 01, 11, 10, 00, each held 8 cycles → exactly 4 `on` pulses, each 1 cycle wide, first pulse after edge k+5; `up_down`=1; counter reads 4.
- **Reverse rotation:** from 00, drive 10, 11, 01, 00, 10 → 5 pulses with `up_down`=0; counter wraps 0→15→14→13→12→11.
- **Glitch rejection:** `enc_a` pulsed high for 2 cycles (`FILTER_LEN`=3) → no `on`, no `err`; the same pulse held 3 cycles → one `on` with `up_down`=0 (00→10).
- **Illegal transition:** switch both channels 00→11 in the same cycle → one `err` pulse, `on`=0, `err_flag`=1 and sticky. Then assert `clr_err` in the same cycle as a second `err` → `err_flag` stays 1. Assert `clr_err` alone → `err_flag`=0.
- **Reset mid-operation:** assert `reset` while a forward step is 2 cycles into filtering → `on` never pulses, all outputs return to reset values, and the next step is accepted only after the 3-cycle arming window plus the normal latency.

Source files
------------

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: two-flop synchronizer and glitch filter per channel,
// followed by a Gray-code step/direction decoder with sticky illegal-transition flag.

module quad_step_channel #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic enc,
    input  logic bypass,
    output logic filt
);
    localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

    logic       s1;
    logic       s2;
    logic [3:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            filt <= 1'b0;
            cnt  <= 4'd0;
        end else begin
            s1 <= enc;
            s2 <= s1;
            // While disarmed the filter follows the synchronizer directly so the
            // resting encoder position is absorbed without being seen as motion.
            if (bypass) begin
                filt <= s2;
                cnt  <= 4'd0;
            end else if (s2 == filt) begin
                cnt <= 4'd0;
            end else if (cnt == CNT_LAST) begin
                filt <= s2;
                cnt  <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end
endmodule

module quad_step_decoder #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    input  logic clr_err,
    output logic on,
    output logic up_down,
    output logic err,
    output logic err_flag
);
    logic       filt_a;
    logic       filt_b;
    logic [1:0] cur;
    logic [1:0] prev;
    logic [1:0] init_cnt;
    logic       init_done;
    logic       armed;
    logic       on_nxt;
    logic       up_nxt;
    logic       err_nxt;

    assign init_done = (init_cnt == 2'd3);
    assign cur       = {filt_a, filt_b};

    quad_step_channel #(.FILTER_LEN(FILTER_LEN)) u_chan_a (
        .clk    (clk),
        .reset  (reset),
        .enc    (enc_a),
        .bypass (~init_done),
        .filt   (filt_a)
    );

    quad_step_channel #(.FILTER_LEN(FILTER_LEN)) u_chan_b (
        .clk    (clk),
        .reset  (reset),
        .enc    (enc_b),
        .bypass (~init_done),
        .filt   (filt_b)
    );

    // Decode masking trails the filter bypass by one cycle so the position loaded
    // during arming has also reached prev before any comparison is allowed to fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_cnt <= 2'd0;
            armed    <= 1'b0;
        end else begin
            if (!init_done) begin
                init_cnt <= init_cnt + 2'd1;
            end
            armed <= init_done;
        end
    end

    // Single-bit Gray moves are up exactly when the old A differs from the new B.
    always_comb begin
        on_nxt  = 1'b0;
        up_nxt  = up_down;
        err_nxt = 1'b0;
        if (armed) begin
            if ((cur ^ prev) == 2'b11) begin
                err_nxt = 1'b1;
            end else if (cur != prev) begin
                on_nxt = 1'b1;
                up_nxt = prev[1] ^ cur[0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev     <= 2'b00;
            on       <= 1'b0;
            up_down  <= 1'b1;
            err      <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            prev     <= cur;
            on       <= on_nxt;
            up_down  <= up_nxt;
            err      <= err_nxt;
            err_flag <= err_nxt | (err_flag & ~clr_err);
        end
    end
endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: reset position, rotation, glitches,
// illegal transitions and reset during filtering, with a model up/down counter.

module tb_quad_step_decoder;
    logic clk = 1'b0;
    logic reset;
    logic enc_a;
    logic enc_b;
    logic clr_err;
    logic on;
    logic up_down;
    logic err;
    logic err_flag;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    int         pulses = 0;
    int         errs   = 0;
    int         both   = 0;
    int         dbl    = 0;
    logic       on_q   = 1'b0;
    logic [3:0] ctr    = 4'd0;

    int         p0;
    int         e0;
    logic [3:0] c0;

    quad_step_decoder #(.FILTER_LEN(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .clr_err  (clr_err),
        .on       (on),
        .up_down  (up_down),
        .err      (err),
        .err_flag (err_flag)
    );

    always #5 clk = ~clk;

    // Downstream counter model plus pulse bookkeeping.
    always @(posedge clk) begin
        #1;
        if (on) begin
            pulses++;
            ctr = up_down ? ctr + 4'd1 : ctr - 4'd1;
        end
        if (err) errs++;
        if (on && err) both++;
        if (on && on_q) dbl++;
        on_q = on;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        p0 = pulses;
        e0 = errs;
        c0 = ctr;
    endtask

    task automatic drive(input logic a, input logic b);
        enc_a = a;
        enc_b = b;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        clr_err = 1'b0;
        drive(1'b1, 1'b1);
        hold(3);
        check("rst_on", 32'(on), 32'd0);
        check("rst_up", 32'(up_down), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_flag", 32'(err_flag), 32'd0);

        snap();
        reset = 1'b0;
        hold(20);
        check("pos11_pulses", 32'(pulses - p0), 32'd0);
        check("pos11_errs", 32'(errs - e0), 32'd0);
        check("pos11_up", 32'(up_down), 32'd1);
        check("pos11_ctr", 32'(ctr - c0), 32'd0);

        reset = 1'b1;
        drive(1'b0, 1'b0);
        hold(2);
        reset = 1'b0;
        hold(10);

        // Forward rotation with exact latency on the first step
        snap();
        drive(1'b0, 1'b1);
        hold(5);
        check("fwd_early", 32'(on), 32'd0);
        hold(1);
        check("fwd_on", 32'(on), 32'd1);
        check("fwd_on_up", 32'(up_down), 32'd1);
        hold(1);
        check("fwd_width", 32'(on), 32'd0);
        hold(1);
        drive(1'b1, 1'b1); hold(8);
        drive(1'b1, 1'b0); hold(8);
        drive(1'b0, 1'b0); hold(8);
        check("fwd_pulses", 32'(pulses - p0), 32'd4);
        check("fwd_ctr", 32'(ctr - c0), 32'd4);
        check("fwd_up", 32'(up_down), 32'd1);
        check("fwd_errs", 32'(errs - e0), 32'd0);

        // Reverse rotation, counter wraps below zero
        snap();
        drive(1'b1, 1'b0); hold(8);
        drive(1'b1, 1'b1); hold(8);
        drive(1'b0, 1'b1); hold(8);
        drive(1'b0, 1'b0); hold(8);
        drive(1'b1, 1'b0); hold(8);
        check("rev_pulses", 32'(pulses - p0), 32'd5);
        check("rev_ctr", 32'(ctr - c0), 32'd11);
        check("rev_up", 32'(up_down), 32'd0);
        check("rev_errs", 32'(errs - e0), 32'd0);

        // Glitch rejection: 2-cycle pulse dropped, 3-cycle pulse accepted
        drive(1'b0, 1'b0); hold(8);
        snap();
        enc_a = 1'b1; hold(2);
        enc_a = 1'b0; hold(12);
        check("gl2_pulses", 32'(pulses - p0), 32'd0);
        check("gl2_errs", 32'(errs - e0), 32'd0);
        check("gl2_up", 32'(up_down), 32'd1);
        snap();
        enc_a = 1'b1; hold(3);
        enc_a = 1'b0; hold(3);
        check("gl3_on", 32'(on), 32'd1);
        check("gl3_up", 32'(up_down), 32'd0);
        check("gl3_pulses", 32'(pulses - p0), 32'd1);
        hold(12);
        check("gl3_ret_pulses", 32'(pulses - p0), 32'd2);
        check("gl3_ret_up", 32'(up_down), 32'd1);
        check("gl3_errs", 32'(errs - e0), 32'd0);

        // Illegal double-bit transition and sticky flag
        snap();
        drive(1'b1, 1'b1);
        hold(5);
        check("ill_early", 32'(err), 32'd0);
        hold(1);
        check("ill_err", 32'(err), 32'd1);
        check("ill_on", 32'(on), 32'd0);
        check("ill_flag_set", 32'(err_flag), 32'd1);
        hold(1);
        check("ill_width", 32'(err), 32'd0);
        hold(6);
        check("ill_sticky", 32'(err_flag), 32'd1);
        check("ill_errs", 32'(errs - e0), 32'd1);
        check("ill_pulses", 32'(pulses - p0), 32'd0);
        check("ill_up", 32'(up_down), 32'd1);

        drive(1'b0, 1'b0);
        hold(5);
        clr_err = 1'b1;
        hold(1);
        clr_err = 1'b0;
        check("ill2_err", 32'(err), 32'd1);
        check("ill2_flag", 32'(err_flag), 32'd1);
        hold(4);
        check("ill2_flag_hold", 32'(err_flag), 32'd1);
        clr_err = 1'b1;
        hold(1);
        clr_err = 1'b0;
        check("clr_flag", 32'(err_flag), 32'd0);

        // Reset while a forward step is in the filter
        drive(1'b1, 1'b0); hold(8);
        snap();
        drive(1'b0, 1'b0);
        hold(4);
        check("mid_up_pre", 32'(up_down), 32'd0);
        reset = 1'b1;
        #1;
        check("mid_on", 32'(on), 32'd0);
        check("mid_up", 32'(up_down), 32'd1);
        check("mid_err", 32'(err), 32'd0);
        check("mid_flag", 32'(err_flag), 32'd0);
        hold(2);
        reset = 1'b0;
        hold(3);
        check("mid_lost", 32'(pulses - p0), 32'd0);
        drive(1'b0, 1'b1);
        hold(5);
        check("mid_early", 32'(on), 32'd0);
        hold(1);
        check("mid_step", 32'(on), 32'd1);
        check("mid_step_up", 32'(up_down), 32'd1);
        hold(5);
        check("mid_total", 32'(pulses - p0), 32'd1);
        check("mid_errs", 32'(errs - e0), 32'd0);

        check("on_err_overlap", 32'(both), 32'd0);
        check("on_double", 32'(dbl), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
